branch_stack: RTL

- Checkpoint stack for the R10K rename path.
- On each branch dispatch it saves a snapshot of the free list and the map table, and hands out a one-hot branch tag.
- On a mispredict it supplies restore_flag, free_list_restore and map_table_restore to the free/complete list block and the map table in the same cycle. It also broadcasts squash and resolve masks to the RS, ROB and execute stages.
- It sits beside dispatch, directly upstream of the free list.

---
 rtl/sys_defs.sv | 29 ++
 rtl/branch_tag_psel.sv | 15 +
 rtl/branch_stack.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared rename-path definitions.
// Sizes of the machine (superscalar width, checkpoint count, register file
// sizes) and the types exchanged between dispatch, the branch stack, the
// free list and the map table.
package sys_defs;

  localparam int N                = 3;   // retire ports
  localparam int B_DEPTH          = 4;   // checkpoints / branch tags
  localparam int PHYS_REG_SZ_R10K = 64;  // physical registers
  localparam int ARCH_REG_SZ      = 32;  // architectural registers

  localparam int PHYS_REG_IDX_W   = $clog2(PHYS_REG_SZ_R10K);
  localparam int NUM_SCALAR_BITS  = $clog2(N + 1);

  typedef logic [PHYS_REG_IDX_W-1:0]   PHYS_REG_IDX;
  typedef logic [B_DEPTH-1:0]          BRANCH_MASK;
  typedef logic [PHYS_REG_SZ_R10K-1:0] FREE_LIST;
  typedef PHYS_REG_IDX [ARCH_REG_SZ-1:0] MAP_TABLE;

  // One saved rename state. dep_mask holds the tags of older branches that
  // were still unresolved when this one dispatched.
  typedef struct packed {
    logic       valid;
    FREE_LIST   free_list;
    MAP_TABLE   map_table;
    BRANCH_MASK dep_mask;
  } CHECKPOINT;

endpackage

// File: rtl/branch_tag_psel.sv
// Lowest-index one-hot priority selector.
// Ports:
//   req   - request vector (the branch stack feeds ~valid)
//   grant - one-hot lowest set bit of req, all zero when req is zero
module branch_tag_psel #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);

  // Two's complement isolates the lowest set bit.
  assign grant = req & (~req + WIDTH'(1));

endmodule

// File: rtl/branch_stack.sv
// Branch checkpoint stack for the R10K rename path.
// Saves a free-list / map-table snapshot per dispatched branch, hands out
// one-hot branch tags, and on a mispredict presents the snapshot and the
// squash mask in the same cycle.
// Ports:
//   clock, reset                       - clock, synchronous active-low reset
//   branch_dispatch_valid              - branch dispatching this cycle
//   dispatch_free_list/_map_table      - rename state after the branch
//   phys_regs_retiring, num_retiring_valid - registers freed by retire
//   resolve_valid/_tag/_mispredict     - branch resolution from execute
//   branch_tag_alloc                   - tag granted to the dispatching branch
//   current_branch_mask, stack_full    - unresolved tags / no tag left
//   restore_flag, free_list_restore, map_table_restore - mispredict restore
//   squash_mask, resolved_mask         - tags squashed / correctly resolved
module branch_stack
  import sys_defs::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            branch_dispatch_valid,
  input  FREE_LIST                        dispatch_free_list,
  input  MAP_TABLE                        dispatch_map_table,
  input  PHYS_REG_IDX [N-1:0]             phys_regs_retiring,
  input  logic [NUM_SCALAR_BITS-1:0]      num_retiring_valid,
  input  logic                            resolve_valid,
  input  BRANCH_MASK                      resolve_tag,
  input  logic                            resolve_mispredict,
  output BRANCH_MASK                      branch_tag_alloc,
  output BRANCH_MASK                      current_branch_mask,
  output logic                            stack_full,
  output logic                            restore_flag,
  output FREE_LIST                        free_list_restore,
  output MAP_TABLE                        map_table_restore,
  output BRANCH_MASK                      squash_mask,
  output BRANCH_MASK                      resolved_mask
);

  CHECKPOINT  ckpt_view [B_DEPTH];
  BRANCH_MASK valid;
  BRANCH_MASK grant;
  BRANCH_MASK younger;
  BRANCH_MASK clear_mask;
  FREE_LIST   retire_bits;
  FREE_LIST   sel_free_list;
  MAP_TABLE   sel_map_table;
  logic       tag_ok;
  logic       mispredict;
  logic       correct;
  logic       alloc_fire;

  branch_tag_psel #(.WIDTH(B_DEPTH)) u_psel (
    .req   (~valid),
    .grant (grant)
  );

  // A resolve only acts when it names exactly one live checkpoint.
  assign tag_ok     = $onehot(resolve_tag) && ((resolve_tag & valid) != '0);
  assign mispredict = resolve_valid && resolve_mispredict && tag_ok;
  assign correct    = resolve_valid && !resolve_mispredict && tag_ok;
  assign stack_full = &valid;
  assign alloc_fire = branch_dispatch_valid && !stack_full && !mispredict;

  always_comb begin
    retire_bits = '0;
    for (int i = 0; i < N; i++) begin
      if (NUM_SCALAR_BITS'(i) < num_retiring_valid)
        retire_bits[phys_regs_retiring[i]] = 1'b1;
    end
  end

  // Snapshot mux and the set of younger branches depending on the resolving tag.
  always_comb begin
    sel_free_list = '0;
    sel_map_table = '0;
    younger       = '0;
    for (int i = 0; i < B_DEPTH; i++) begin
      if (resolve_tag[i]) begin
        sel_free_list = ckpt_view[i].free_list;
        sel_map_table = ckpt_view[i].map_table;
      end
      if (valid[i] && ((ckpt_view[i].dep_mask & resolve_tag) != '0))
        younger[i] = 1'b1;
    end
  end

  assign branch_tag_alloc    = grant;
  assign current_branch_mask = valid;
  assign restore_flag        = mispredict;
  assign free_list_restore   = mispredict ? sel_free_list : '0;
  assign map_table_restore   = mispredict ? sel_map_table : '0;
  assign squash_mask         = mispredict ? (resolve_tag | younger) : '0;
  assign resolved_mask       = correct ? resolve_tag : '0;
  assign clear_mask          = squash_mask | resolved_mask;

  genvar gi;
  generate
    for (gi = 0; gi < B_DEPTH; gi++) begin : g_ckpt
      CHECKPOINT ckpt_reg;

      always_ff @(posedge clock) begin
        if (!reset) begin
          ckpt_reg <= '0;
        end else if (alloc_fire && grant[gi]) begin
          ckpt_reg.valid     <= 1'b1;
          ckpt_reg.free_list <= dispatch_free_list | retire_bits;
          ckpt_reg.map_table <= dispatch_map_table;
          ckpt_reg.dep_mask  <= valid & ~resolved_mask;
        end else if (ckpt_reg.valid) begin
          ckpt_reg.free_list <= ckpt_reg.free_list | retire_bits;
          // Dropping squashed bits too keeps dep_mask limited to live tags.
          ckpt_reg.dep_mask  <= ckpt_reg.dep_mask & ~clear_mask;
          if (clear_mask[gi])
            ckpt_reg.valid <= 1'b0;
        end
      end

      assign ckpt_view[gi] = ckpt_reg;
      assign valid[gi]     = ckpt_reg.valid;
    end
  endgenerate

  dispatch_not_full: assert property (@(posedge clock) disable iff (!reset)
    !(branch_dispatch_valid && stack_full));
  resolve_tag_legal: assert property (@(posedge clock) disable iff (!reset)
    resolve_valid |-> tag_ok);

endmodule
